// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 memory access sequencer.
// Imported by mem_wait_cnt and mem_access_seq.
package slc3_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DONE,
        WR_SETUP,
        WR_PULSE,
        WR_DONE
    } mem_state_t;

    localparam logic [15:0] MMIO_ADDR_DEF = 16'hFFFF;
    localparam int          WAIT_W        = 4;

endpackage

// File: rtl/mem_wait_cnt.sv
// Loadable down-counter for SRAM wait states.
// One instance is shared by the read-wait and write-pulse phases.
module mem_wait_cnt
    import slc3_mem_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_val,
    input  logic              dec,
    output logic              done
);

    logic [WAIT_W-1:0] cnt;

    // Load on entry to a wait phase, then count down and stick at zero
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/mem_access_seq.sv
// SLC-3 memory access sequencer: datapath MAR/MDR <-> async SRAM.
// Optional SLC3_MMIO_EN: MMIO_ADDR maps to SW (read) and HEX_Out (write).
module mem_access_seq
    import slc3_mem_pkg::*;
#(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] MMIO_ADDR   = MMIO_ADDR_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    output logic [15:0] MDR_In,
    output logic        MIO_EN,
    output logic        ready,
    output logic        proto_err,
    output logic [15:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_O,
    output logic        SRAM_DQ_OE,
    input  logic [15:0] SRAM_DQ_I,
    output logic        SRAM_CE_n,
    output logic        SRAM_OE_n,
    output logic        SRAM_WE_n,
    input  logic [9:0]  SW,
    output logic [15:0] HEX_Out
);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("WAIT_CYCLES must be in 1..15");
    end

    localparam logic [WAIT_W-1:0] WAIT_LOAD =
        WAIT_W'(WAIT_CYCLES - 1);

    mem_state_t  state;
    mem_state_t  state_n;
    logic        cnt_load;
    logic        cnt_dec;
    logic        cnt_done;
    logic        accept;
    logic        is_mmio;
    logic        lat_mmio;
    logic [15:0] lat_addr;
    logic [15:0] lat_data;
    logic [15:0] mdr_in_q;

    mem_wait_cnt u_wait (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     (cnt_load),
        .load_val (WAIT_LOAD),
        .dec      (cnt_dec),
        .done     (cnt_done)
    );

    assign accept = (state == IDLE) && (rd_req || wr_req);

`ifdef SLC3_MMIO_EN
    assign is_mmio = (MAR == MMIO_ADDR);
`else
    logic unused_mmio;
    assign is_mmio     = 1'b0;
    assign unused_mmio = ^{SW, MMIO_ADDR};
`endif

    // State register; reset aborts any access in flight
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, counter control and SRAM strobes per state
    always_comb begin
        state_n    = state;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        SRAM_CE_n  = 1'b1;
        SRAM_OE_n  = 1'b1;
        SRAM_WE_n  = 1'b1;
        SRAM_DQ_OE = 1'b0;
        MIO_EN     = 1'b0;
        ready      = 1'b0;
        unique case (state)
            IDLE: begin
                if (rd_req) begin
                    if (is_mmio) begin
                        state_n = RD_DONE;
                    end else begin
                        state_n  = RD_WAIT;
                        cnt_load = 1'b1;
                    end
                end else if (wr_req) begin
                    state_n = is_mmio ? WR_DONE : WR_SETUP;
                end
            end
            RD_WAIT: begin
                SRAM_CE_n = 1'b0;
                SRAM_OE_n = 1'b0;
                if (cnt_done) begin
                    state_n = RD_DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RD_DONE: begin
                SRAM_CE_n = lat_mmio;
                SRAM_OE_n = lat_mmio;
                MIO_EN    = 1'b1;
                ready     = 1'b1;
                state_n   = IDLE;
            end
            WR_SETUP: begin
                SRAM_CE_n  = 1'b0;
                SRAM_DQ_OE = 1'b1;
                cnt_load   = 1'b1;
                state_n    = WR_PULSE;
            end
            WR_PULSE: begin
                SRAM_CE_n  = 1'b0;
                SRAM_DQ_OE = 1'b1;
                SRAM_WE_n  = 1'b0;
                if (cnt_done) begin
                    state_n = WR_DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            WR_DONE: begin
                SRAM_CE_n  = lat_mmio;
                SRAM_DQ_OE = !lat_mmio;
                ready      = 1'b1;
                state_n    = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Request latching, read-data capture, sticky protocol error
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            lat_addr  <= '0;
            lat_data  <= '0;
            lat_mmio  <= 1'b0;
            proto_err <= 1'b0;
            mdr_in_q  <= '0;
`ifdef SLC3_MMIO_EN
            HEX_Out   <= '0;
`endif
        end else begin
            if (accept) begin
                lat_addr <= MAR;
                lat_data <= MDR;
                lat_mmio <= is_mmio;
                if (rd_req && wr_req) begin
                    proto_err <= 1'b1;
                end
            end
            if ((state == RD_WAIT) && cnt_done) begin
                mdr_in_q <= SRAM_DQ_I;
            end
`ifdef SLC3_MMIO_EN
            if (accept && is_mmio) begin
                if (rd_req) begin
                    mdr_in_q <= {6'b0, SW};
                end else begin
                    HEX_Out <= MDR;
                end
            end
`endif
        end
    end

`ifndef SLC3_MMIO_EN
    assign HEX_Out = '0;
`endif

    assign SRAM_ADDR = lat_addr;
    assign SRAM_DQ_O = lat_data;
    assign MDR_In    = mdr_in_q;

endmodule

// File: tb/tb_mem_access_seq.sv
// Scoreboard bench for mem_access_seq with a behavioural async SRAM.
// MMIO checks follow the SLC3_MMIO_EN build option.
module tb_mem_access_seq;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        rd_req = 1'b0;
    logic        wr_req = 1'b0;
    logic [15:0] MAR = '0;
    logic [15:0] MDR = '0;
    logic [15:0] MDR_In;
    logic        MIO_EN;
    logic        ready;
    logic        proto_err;
    logic [15:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_O;
    logic        SRAM_DQ_OE;
    logic [15:0] SRAM_DQ_I;
    logic        SRAM_CE_n;
    logic        SRAM_OE_n;
    logic        SRAM_WE_n;
    logic [9:0]  SW = '0;
    logic [15:0] HEX_Out;

    mem_access_seq #(.WAIT_CYCLES(2)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .rd_req     (rd_req),
        .wr_req     (wr_req),
        .MAR        (MAR),
        .MDR        (MDR),
        .MDR_In     (MDR_In),
        .MIO_EN     (MIO_EN),
        .ready      (ready),
        .proto_err  (proto_err),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_DQ_O  (SRAM_DQ_O),
        .SRAM_DQ_OE (SRAM_DQ_OE),
        .SRAM_DQ_I  (SRAM_DQ_I),
        .SRAM_CE_n  (SRAM_CE_n),
        .SRAM_OE_n  (SRAM_OE_n),
        .SRAM_WE_n  (SRAM_WE_n),
        .SW         (SW),
        .HEX_Out    (HEX_Out)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        rd;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          we_low = 0;
    logic        ce_low_seen = 1'b0;
    logic        inv_bad = 1'b0;
    logic [15:0] mem [0:65535];
    logic        pend = 1'b0;
    logic [15:0] paddr = '0;
    logic [15:0] pdata = '0;

    assign SRAM_DQ_I = mem[SRAM_ADDR];

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // SRAM model: data latched while WE_n low, committed when WE_n
    // rises with CE_n still low; an aborted pulse commits nothing.
    always @(negedge Clk) begin
        if (!SRAM_CE_n && !SRAM_WE_n) begin
            pend  = 1'b1;
            paddr = SRAM_ADDR;
            pdata = SRAM_DQ_O;
        end else begin
            if (pend && !SRAM_CE_n && SRAM_DQ_OE) mem[paddr] = pdata;
            pend = 1'b0;
        end
        if (!SRAM_WE_n) we_low++;
        if (!SRAM_CE_n) ce_low_seen = 1'b1;
        if (Reset && ((!SRAM_OE_n && !SRAM_WE_n) ||
                      (SRAM_DQ_OE && !SRAM_OE_n))) inv_bad = 1'b1;
    end

    // Monitor: every ready pulse consumes one expected response
    always @(negedge Clk) begin
        exp_t e;
        if (Reset && ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_ready", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("ready_cycle", 32'(cyc), 32'(e.cyc));
                chk("mio_en", {31'd0, MIO_EN}, {31'd0, e.rd});
                if (e.rd) chk("mdr_in", {16'd0, MDR_In}, {16'd0, e.data});
            end
        end
    end

    task automatic issue(input logic rd, input logic wr,
                         input logic [15:0] addr, input logic [15:0] data,
                         input int lat, input logic [15:0] exp_data);
        exp_t e;
        @(negedge Clk);
        rd_req = rd;
        wr_req = wr;
        MAR    = addr;
        MDR    = data;
        e.rd   = rd;
        e.data = exp_data;
        e.cyc  = cyc + lat;
        sb.push_back(e);
        @(negedge Clk);
        rd_req = 1'b0;
        wr_req = 1'b0;
        MAR    = 16'h0BAD;
        MDR    = 16'hDEAD;
        repeat (lat + 2) @(negedge Clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h3000] = 16'hBEEF;
        mem[16'h0010] = 16'h5A5A;

        repeat (3) @(negedge Clk);
        chk("rst_mdr_in", {16'd0, MDR_In}, 32'h0);
        chk("rst_mio_en", {31'd0, MIO_EN}, 32'h0);
        chk("rst_ready", {31'd0, ready}, 32'h0);
        chk("rst_proto_err", {31'd0, proto_err}, 32'h0);
        chk("rst_sram_addr", {16'd0, SRAM_ADDR}, 32'h0);
        chk("rst_sram_dq_o", {16'd0, SRAM_DQ_O}, 32'h0);
        chk("rst_dq_oe", {31'd0, SRAM_DQ_OE}, 32'h0);
        chk("rst_strobes", {29'd0, SRAM_CE_n, SRAM_OE_n, SRAM_WE_n}, 32'h7);
        chk("rst_hex", {16'd0, HEX_Out}, 32'h0);
        Reset = 1'b1;

        issue(1'b1, 1'b0, 16'h3000, 16'h0000, 3, 16'hBEEF);

        we_low = 0;
        issue(1'b0, 1'b1, 16'h0042, 16'h1234, 4, 16'h0000);
        chk("wr_we_low_cycles", 32'(we_low), 32'd2);
        chk("wr_mem_0042", {16'd0, mem[16'h0042]}, 32'h1234);

        issue(1'b1, 1'b0, 16'h0042, 16'h0000, 3, 16'h1234);

        issue(1'b1, 1'b1, 16'h0010, 16'hDEAD, 3, 16'h5A5A);
        chk("both_proto_err", {31'd0, proto_err}, 32'h1);
        chk("both_no_write", {16'd0, mem[16'h0010]}, 32'h5A5A);

        issue(1'b0, 1'b1, 16'h0020, 16'h7777, 4, 16'h0000);
        chk("proto_err_sticky", {31'd0, proto_err}, 32'h1);
        chk("mdr_in_hold", {16'd0, MDR_In}, 32'h5A5A);
        chk("wr_mem_0020", {16'd0, mem[16'h0020]}, 32'h7777);

`ifdef SLC3_MMIO_EN
        SW = 10'h2A5;
        ce_low_seen = 1'b0;
        issue(1'b1, 1'b0, 16'hFFFF, 16'h0000, 1, 16'h02A5);
        chk("mmio_rd_ce_idle", {31'd0, ce_low_seen}, 32'h0);
        ce_low_seen = 1'b0;
        issue(1'b0, 1'b1, 16'hFFFF, 16'hABCD, 1, 16'h0000);
        chk("mmio_wr_hex", {16'd0, HEX_Out}, 32'hABCD);
        chk("mmio_wr_ce_idle", {31'd0, ce_low_seen}, 32'h0);
        chk("mmio_wr_no_sram", {16'd0, mem[16'hFFFF]}, 32'h0);
`else
        SW = 10'h2A5;
        issue(1'b0, 1'b1, 16'hFFFF, 16'hABCD, 4, 16'h0000);
        chk("nommio_wr_sram", {16'd0, mem[16'hFFFF]}, 32'hABCD);
        chk("nommio_hex", {16'd0, HEX_Out}, 32'h0);
        issue(1'b1, 1'b0, 16'hFFFF, 16'h0000, 3, 16'hABCD);
`endif

        issue(1'b0, 1'b1, 16'h0050, 16'h1111, 4, 16'h0000);
        chk("wr_mem_0050", {16'd0, mem[16'h0050]}, 32'h1111);

        @(negedge Clk);
        wr_req = 1'b1;
        MAR    = 16'h0050;
        MDR    = 16'h2222;
        @(negedge Clk);
        wr_req = 1'b0;
        @(negedge Clk);
        chk("abort_in_pulse", {31'd0, SRAM_WE_n}, 32'h0);
        #2;
        Reset = 1'b0;
        #1;
        chk("abort_we_n", {31'd0, SRAM_WE_n}, 32'h1);
        chk("abort_ce_n", {31'd0, SRAM_CE_n}, 32'h1);
        chk("abort_ready", {31'd0, ready}, 32'h0);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        chk("abort_mem_0050", {16'd0, mem[16'h0050]}, 32'h1111);
        chk("abort_proto_clr", {31'd0, proto_err}, 32'h0);
        chk("abort_mdr_in_clr", {16'd0, MDR_In}, 32'h0);

        repeat (4) @(negedge Clk);
        chk("strobe_invariant", {31'd0, inv_bad}, 32'h0);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
